// File: rtl/if_stage_controller.sv
// if_stage_controller
//   Instruction-fetch stage for the 5-stage MIPS pipeline. Owns the PC, the
//   IF/ID pipeline register and the instruction-memory request handshake.
//   Applies stall / flush / branch / jump commands from hazard detection and
//   copes with a multi-cycle instruction memory.
//
// Ports
//   clk, rst          pipeline clock, asynchronous active-high reset
//   holdPC            freeze PC and IF/ID this cycle
//   IF_ID_Flush       load a bubble into IF/ID this cycle
//   isBranch          taken branch (target = branch_pc_plus4 + PC_offset*4)
//   PC_offset         sign-extended word offset of the branch
//   branch_pc_plus4   PC+4 of the branch instruction
//   isJump            jump to jump_target
//   jump_target       absolute jump byte address
//   imem_req          fetch request valid (imem_addr stable while high)
//   imem_addr         fetch byte address (always equals PC)
//   imem_ready        read data valid; completes the request
//   imem_rdata        instruction word
//   PC_IF_ID          PC+4 of the instruction in IF/ID
//   instr_IF_ID       instruction in IF/ID
//   valid_IF_ID       IF/ID holds a real instruction
module if_stage_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        holdPC,
    input  logic        IF_ID_Flush,
    input  logic        isBranch,
    input  logic [31:0] PC_offset,
    input  logic [31:0] branch_pc_plus4,
    input  logic        isJump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_IF_ID,
    output logic [31:0] instr_IF_ID,
    output logic        valid_IF_ID
);

    localparam logic [1:0] FETCH = 2'd0;  // request outstanding at PC
    localparam logic [1:0] HOLD  = 2'd1;  // fetched word parked in skid buffer
    localparam logic [1:0] DRAIN = 2'd2;  // redirected; finishing old request

    logic [1:0]  state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] skid, skid_next;
    logic [31:0] pending, pending_next;
    logic [31:0] if_pc, if_pc_next;
    logic [31:0] if_instr, if_instr_next;
    logic        if_valid, if_valid_next;

    logic        redirect;
    logic [31:0] target;
    logic        load;
    logic [31:0] load_word;

    assign redirect = isBranch | isJump;
    assign target   = isBranch ? (branch_pc_plus4 + (PC_offset << 2)) : jump_target;

    // Gated by rst so the request drops the instant reset asserts.
    assign imem_req    = ~rst & (state != HOLD);
    assign imem_addr   = pc;
    assign PC_IF_ID    = if_pc;
    assign instr_IF_ID = if_instr;
    assign valid_IF_ID = if_valid;

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        skid_next     = skid;
        pending_next  = pending;
        if_pc_next    = if_pc;
        if_instr_next = if_instr;
        if_valid_next = if_valid;
        load          = 1'b0;
        load_word     = imem_rdata;

        case (state)
            FETCH: begin
                if (redirect) begin
                    if (imem_ready) begin
                        pc_next = target;
                    end else begin
                        // Address must stay put until the memory answers.
                        pending_next = target;
                        state_next   = DRAIN;
                    end
                end else if (imem_ready) begin
                    if (holdPC) begin
                        skid_next  = imem_rdata;
                        state_next = HOLD;
                    end else begin
                        load    = 1'b1;
                        pc_next = pc + 32'd4;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next    = target;
                    state_next = FETCH;
                end else if (!holdPC) begin
                    load       = 1'b1;
                    load_word  = skid;
                    pc_next    = pc + 32'd4;
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pending_next = target;
                end
                if (imem_ready) begin
                    // A redirect on the completing edge is the newest one.
                    pc_next    = redirect ? target : pending;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase

        // A flush (explicit or implied by a redirect) squashes whatever would
        // have entered IF/ID on this edge.
        if (redirect || IF_ID_Flush) begin
            if_pc_next    = '0;
            if_instr_next = NOP_INSTR;
            if_valid_next = 1'b0;
        end else if (load) begin
            if_pc_next    = pc + 32'd4;
            if_instr_next = load_word;
            if_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            skid     <= '0;
            pending  <= '0;
            if_pc    <= '0;
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            skid     <= skid_next;
            pending  <= pending_next;
            if_pc    <= if_pc_next;
            if_instr <= if_instr_next;
            if_valid <= if_valid_next;
        end
    end

endmodule

// File: tb/tb_if_stage_controller.sv
module tb_if_stage_controller;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        holdPC, IF_ID_Flush, isBranch, isJump, imem_ready;
    logic [31:0] PC_offset, branch_pc_plus4, jump_target, imem_rdata;
    logic        imem_req, valid_IF_ID;
    logic [31:0] imem_addr, PC_IF_ID, instr_IF_ID;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model: fetch pointer, a parked word, a redirect waiting for
    // the old request to finish, and the expected IF/ID contents.
    logic [31:0] m_pc;
    logic        m_parked;
    logic [31:0] m_parked_word;
    logic        m_draining;
    logic [31:0] m_drain_to;
    logic [31:0] e_pc, e_instr;
    logic        e_valid;

    logic        want_ready;

    if_stage_controller #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .holdPC         (holdPC),
        .IF_ID_Flush    (IF_ID_Flush),
        .isBranch       (isBranch),
        .PC_offset      (PC_offset),
        .branch_pc_plus4(branch_pc_plus4),
        .isJump         (isJump),
        .jump_target    (jump_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .PC_IF_ID       (PC_IF_ID),
        .instr_IF_ID    (instr_IF_ID),
        .valid_IF_ID    (valid_IF_ID)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = RST_PC;
        m_parked   = 1'b0;
        m_parked_word = '0;
        m_draining = 1'b0;
        m_drain_to = '0;
        e_pc       = '0;
        e_instr    = NOP;
        e_valid    = 1'b0;
    endtask

    // One rising edge of the behavioural model.
    task automatic model_edge();
        logic        redir, kill;
        logic [31:0] dest;
        if (rst) begin
            model_reset();
            return;
        end
        redir = isBranch | isJump;
        kill  = redir | IF_ID_Flush;
        dest  = isBranch ? branch_pc_plus4 + PC_offset * 32'd4 : jump_target;
        if (m_parked) begin
            if (redir) begin
                m_parked = 1'b0;
                m_pc     = dest;
            end else if (!holdPC) begin
                if (!kill) begin
                    e_pc = m_pc + 32'd4; e_instr = m_parked_word; e_valid = 1'b1;
                end
                m_parked = 1'b0;
                m_pc     = m_pc + 32'd4;
            end
        end else if (m_draining) begin
            if (redir) m_drain_to = dest;
            if (imem_ready) begin
                m_pc       = m_drain_to;
                m_draining = 1'b0;
            end
        end else if (redir) begin
            if (imem_ready) m_pc = dest;
            else begin
                m_draining = 1'b1;
                m_drain_to = dest;
            end
        end else if (imem_ready) begin
            if (holdPC) begin
                m_parked      = 1'b1;
                m_parked_word = imem_rdata;
            end else begin
                if (!kill) begin
                    e_pc = m_pc + 32'd4; e_instr = imem_rdata; e_valid = 1'b1;
                end
                m_pc = m_pc + 32'd4;
            end
        end
        if (kill) begin
            e_pc = '0; e_instr = NOP; e_valid = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".req"},   {31'd0, imem_req}, {31'd0, ~rst & ~m_parked});
        check({tag, ".addr"},  imem_addr,   m_pc);
        check({tag, ".ifpc"},  PC_IF_ID,    e_pc);
        check({tag, ".instr"}, instr_IF_ID, e_instr);
        check({tag, ".valid"}, {31'd0, valid_IF_ID}, {31'd0, e_valid});
    endtask

    // Starts and ends at a falling edge. The memory answers with its own
    // address as the data word, and only while a request is expected.
    task automatic cyc(input string tag);
        imem_rdata = m_pc;
        imem_ready = want_ready & ~m_parked & ~rst;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        holdPC = 1'b0; IF_ID_Flush = 1'b0; isBranch = 1'b0; isJump = 1'b0;
        PC_offset = '0; branch_pc_plus4 = '0; jump_target = '0; want_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        imem_ready = 1'b0;
        imem_rdata = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset.req",   {31'd0, imem_req}, 32'd0);
        check("reset.addr",  imem_addr, RST_PC);
        check("reset.valid", {31'd0, valid_IF_ID}, 32'd0);
        check("reset.instr", instr_IF_ID, NOP);
        check("reset.ifpc",  PC_IF_ID, 32'd0);
        rst = 1'b0;
        #1;
        check("post_reset.req", {31'd0, imem_req}, 32'd1);

        // Zero-wait sequential fetch up to PC=8.
        want_ready = 1'b1;
        cyc("seq0");
        cyc("seq1");
        // Three wait states at PC=8, then two more fetches.
        want_ready = 1'b0;
        repeat (3) cyc("wait");
        check("wait.addr", imem_addr, 32'h8);
        want_ready = 1'b1;
        cyc("wait_done");
        check("wait_done.instr", instr_IF_ID, 32'h8);
        cyc("seq3");

        // Load-use bubble with the memory answering at PC=16.
        holdPC = 1'b1; IF_ID_Flush = 1'b1;
        cyc("loaduse");
        check("loaduse.valid", {31'd0, valid_IF_ID}, 32'd0);
        holdPC = 1'b0; IF_ID_Flush = 1'b0;
        cyc("loaduse_release");
        check("loaduse.instr", instr_IF_ID, 32'h10);
        check("loaduse.addr",  imem_addr, 32'h14);

        // Taken branch: 0x20 + (-2)*4 = 0x18.
        isBranch = 1'b1; branch_pc_plus4 = 32'h20; PC_offset = 32'hFFFF_FFFE;
        cyc("branch");
        check("branch.addr", imem_addr, 32'h18);
        isBranch = 1'b0;
        for (int i = 0; i < 20 && m_pc != 32'h40; i++) cyc("to40");
        check("at40.addr", imem_addr, 32'h40);

        // Jump while the request at 0x40 is still outstanding.
        want_ready = 1'b0; isJump = 1'b1; jump_target = 32'h100;
        cyc("jump_wait");
        isJump = 1'b0;
        cyc("drain");
        check("drain.addr", imem_addr, 32'h40);
        want_ready = 1'b1;
        cyc("drain_done");
        check("jump.addr", imem_addr, 32'h100);

        // Branch and jump together: branch wins (0x200 + 4*4 = 0x210).
        isBranch = 1'b1; branch_pc_plus4 = 32'h200; PC_offset = 32'd4;
        isJump = 1'b1; jump_target = 32'h300;
        cyc("br_jmp");
        check("br_jmp.addr", imem_addr, 32'h210);
        idle_inputs();
        want_ready = 1'b1;
        cyc("refill");

        // Park a word, then reset asynchronously between edges.
        holdPC = 1'b1;
        cyc("park");
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("async_rst.req",   {31'd0, imem_req}, 32'd0);
        check("async_rst.valid", {31'd0, valid_IF_ID}, 32'd0);
        check("async_rst.addr",  imem_addr, RST_PC);
        @(negedge clk);
        rst = 1'b0;
        holdPC = 1'b0;
        cyc("restart");
        check("restart.ifpc", PC_IF_ID, 32'h4);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            holdPC      = ($urandom_range(0, 99) < 25);
            IF_ID_Flush = ($urandom_range(0, 99) < 10);
            isBranch    = ($urandom_range(0, 99) < 8);
            isJump      = ($urandom_range(0, 99) < 8);
            PC_offset   = 32'($urandom_range(0, 63)) - 32'd32;
            branch_pc_plus4 = $urandom & 32'hFFFF_FFFC;
            jump_target     = $urandom & 32'hFFFF_FFFC;
            want_ready  = ($urandom_range(0, 99) < 60);
            rst         = ($urandom_range(0, 99) < 2);
            cyc("rand");
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
